freq_meter: RTL and testbench

- Measures the frequency of an external, asynchronous square-wave input against the system clock, so it complements the existing clock divider.
- Where the divider derives a 1 Hz tick from the 40 kHz system clock, this block counts rising edges of the input over a gate window of exactly GATE_CYCLES system clocks (1 s by default). It then reports the count.
- The result is the input frequency in Hz when GATE_CYCLES equals CLK_FREQ.
- Sits next to the clock tree utilities and feeds status, display or self-test logic.

---
 rtl/freq_meter.sv | 112 +++++++++++
 tb/tb_freq_meter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a gate
// window of GATE_CYCLES system clocks and reports the count. With
// GATE_CYCLES == CLK_FREQ the result is the input frequency in Hz.
module freq_meter #(
    parameter int unsigned CLK_FREQ    = 40_000,
    parameter int unsigned GATE_CYCLES = CLK_FREQ,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned GATE_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig_in,
    input  logic                 start,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] freq_out,
    output logic                 valid,
    output logic                 overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GATE = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    logic [1:0]            state;
    logic                  s1, s2, s3;
    logic                  rise;
    logic [GATE_WIDTH-1:0] gate_cnt;
    logic [CNT_WIDTH-1:0]  edge_cnt;
    logic [CNT_WIDTH-1:0]  edge_nxt;
    logic                  sat;
    logic                  sat_nxt;
    logic                  gate_end;

    // Two-flop synchronizer plus history flop; runs in every state so a
    // level held before start never looks like a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign gate_end = (gate_cnt == GATE_LAST);

    // Next edge count with saturation; an edge arriving at full scale
    // raises the saturation flag instead of wrapping.
    always_comb begin
        edge_nxt = edge_cnt;
        sat_nxt  = sat;
        if (rise) begin
            if (edge_cnt == CNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Measurement FSM. The result registers load on the last gate cycle
    // (using the next-count value, so an edge in that cycle is included);
    // this lines the new freq_out up with the DONE cycle where valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq_out <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                        state    <= GATE;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + GATE_WIDTH'(1);
                    edge_cnt <= edge_nxt;
                    sat      <= sat_nxt;
                    if (gate_end) begin
                        freq_out <= edge_nxt;
                        overflow <= sat_nxt;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: three freq_meter instances (default 1 s gate, small
// 8-bit counter with 1000-cycle gate, 10-cycle gate) sharing clock, reset
// and sig_in. Stimulus pushes expected windows into a scoreboard; a
// negedge monitor pops them and checks against an edge-time model.
module tb_freq_meter;

    localparam int NDUT = 3;
    localparam int GC0  = 40000;
    localparam int GC1  = 1000;
    localparam int GC2  = 10;
    localparam int CW0  = 16;
    localparam int CW1  = 8;
    localparam int CW2  = 16;

    int gc_of [NDUT] = '{GC0, GC1, GC2};
    int cw_of [NDUT] = '{CW0, CW1, CW2};

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sig_in;
    logic [2:0]     start_v;
    logic [2:0]     busy_v;
    logic [2:0]     valid_v;
    logic [2:0]     ovf_v;
    logic [CW0-1:0] f0;
    logic [CW1-1:0] f1;
    logic [CW2-1:0] f2;
    logic [15:0]    freq_v [NDUT];

    assign freq_v[0] = f0;
    assign freq_v[1] = {8'd0, f1};
    assign freq_v[2] = f2;

    freq_meter #(.GATE_CYCLES(GC0), .CNT_WIDTH(CW0), .GATE_WIDTH(16)) u_def (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_v[0]),
        .busy(busy_v[0]), .freq_out(f0), .valid(valid_v[0]), .overflow(ovf_v[0])
    );

    freq_meter #(.GATE_CYCLES(GC1), .CNT_WIDTH(CW1), .GATE_WIDTH(10)) u_sat (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_v[1]),
        .busy(busy_v[1]), .freq_out(f1), .valid(valid_v[1]), .overflow(ovf_v[1])
    );

    freq_meter #(.GATE_CYCLES(GC2), .CNT_WIDTH(CW2), .GATE_WIDTH(4)) u_gt (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_v[2]),
        .busy(busy_v[2]), .freq_out(f2), .valid(valid_v[2]), .overflow(ovf_v[2])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int n;
    } exp_t;

    exp_t sbq[$];
    int   edge_log[$];
    int   acc_n    [NDUT] = '{-1000000, -1000000, -1000000};
    int   exp_freq [NDUT] = '{0, 0, 0};
    int   exp_ovf  [NDUT] = '{0, 0, 0};
    int   n_exp    [NDUT] = '{0, 0, 0};
    int   n_seen   [NDUT] = '{0, 0, 0};
    int   last_vc  [NDUT] = '{0, 0, 0};
    int   prev_vc  [NDUT] = '{0, 0, 0};
    int   checks = 0;
    int   errors = 0;
    int   gen_on = 0;
    int   hp_lo  = 1;
    int   hp_hi  = 1;
    int   hcnt   = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // A measurement accepted at edge n keeps the block busy through edge n+gc.
    function automatic bit model_busy(input int d, input int c);
        return (c >= acc_n[d]) && (c <= acc_n[d] + gc_of[d]);
    endfunction

    // Edge driven after edge E is counted iff it reaches the counter
    // (3 edges later) inside the gate, i.e. E in [n-2, n+gc-3].
    function automatic int raw_edges(input int n, input int gc);
        int k = 0;
        foreach (edge_log[i])
            if (edge_log[i] >= n - 2 && edge_log[i] <= n + gc - 3) k++;
        return k;
    endfunction

    function automatic bit pending(input int d);
        foreach (sbq[i]) if (sbq[i].d == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sig(input logic v);
        if (v && !sig_in) edge_log.push_back(cyc);
        sig_in = v;
    endtask

    // Background square-wave generator with random half-periods in [hp_lo, hp_hi].
    initial begin
        forever begin
            tick();
            if (gen_on != 0) begin
                if (hcnt <= 0) begin
                    drive_sig(~sig_in);
                    hcnt = int'($urandom_range(hp_hi, hp_lo)) - 1;
                end else begin
                    hcnt--;
                end
            end
        end
    end

    task automatic issue_start(input int d);
        start_v[d] = 1'b1;
        if (rst_n && !model_busy(d, cyc)) begin
            acc_n[d] = cyc + 1;
            sbq.push_back('{d: d, n: cyc + 1});
            n_exp[d]++;
        end
        tick();
        start_v[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        int b = budget;
        while (pending(d) && b > 0) begin
            tick();
            b--;
        end
        check($sformatf("done_in_time[%0d]", d), int'(pending(d)), 0);
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].d == d) begin
                sbq.delete(i);
                n_exp[d]--;
            end
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        foreach (sbq[i]) n_exp[sbq[i].d]--;
        sbq.delete();
        for (int d = 0; d < NDUT; d++) begin
            acc_n[d]    = -1000000;
            exp_freq[d] = 0;
            exp_ovf[d]  = 0;
        end
        repeat (ncyc) tick();
        rst_n = 1'b1;
    endtask

    // Per-DUT monitor: busy, valid timing, and held/new result each cycle.
    task automatic mon(input int d);
        int idx = -1;
        bit due;
        int raw;
        int cap;
        for (int i = 0; i < sbq.size(); i++)
            if (idx < 0 && sbq[i].d == d) idx = i;
        due = (idx >= 0) && (sbq[idx].n + gc_of[d] == cyc);
        check($sformatf("busy[%0d]", d), int'(busy_v[d]), int'(model_busy(d, cyc)));
        check($sformatf("valid[%0d]", d), int'(valid_v[d]), int'(due));
        if (due) begin
            raw = raw_edges(sbq[idx].n, gc_of[d]);
            cap = (1 << cw_of[d]) - 1;
            exp_freq[d] = (raw > cap) ? cap : raw;
            exp_ovf[d]  = (raw > cap) ? 1 : 0;
            sbq.delete(idx);
        end
        if (valid_v[d]) begin
            n_seen[d]++;
            prev_vc[d] = last_vc[d];
            last_vc[d] = cyc;
        end
        check($sformatf("freq_out[%0d]", d), int'(freq_v[d]), exp_freq[d]);
        check($sformatf("overflow[%0d]", d), int'(ovf_v[d]), exp_ovf[d]);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) mon(d);
    end

    initial begin
        int n1;
        rst_n   = 1'b0;
        sig_in  = 1'b0;
        start_v = '0;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Exact gate timing on the 10-cycle instance, input idle.
        issue_start(2);
        wait_idle(2, 40);

        // Static high level: no edge counted.
        drive_sig(1'b1);
        repeat (5) tick();
        issue_start(1);
        wait_idle(1, GC1 + 20);
        check("static_high_cnt", int'(f1), 0);
        drive_sig(1'b0);
        repeat (5) tick();

        // Single rise mid-window.
        issue_start(1);
        repeat (300) tick();
        drive_sig(1'b1);
        wait_idle(1, GC1 + 20);
        check("single_rise_cnt", int'(f1), 1);
        drive_sig(1'b0);
        repeat (5) tick();

        // Saturation: toggle every clock, 500 edges into an 8-bit counter.
        hp_lo  = 1;
        hp_hi  = 1;
        hcnt   = 0;
        gen_on = 1;
        repeat (3) tick();
        issue_start(1);
        wait_idle(1, GC1 + 20);
        check("sat_cnt", int'(f1), 255);
        check("sat_ovf", int'(ovf_v[1]), 1);

        // Period 40 afterwards: 25 +/- 1, no overflow.
        hp_lo = 20;
        hp_hi = 20;
        repeat (50) tick();
        issue_start(1);
        wait_idle(1, GC1 + 20);
        check("p40_cnt_in_range", int'(f1 >= 8'd24 && f1 <= 8'd26), 1);
        check("p40_ovf", int'(ovf_v[1]), 0);

        // Start ignored mid-gate and in DONE; restart on first IDLE cycle.
        repeat (7) tick();
        issue_start(1);
        n1 = acc_n[1];
        repeat (100) tick();
        issue_start(1);
        wait_until(n1 + GC1);
        issue_start(1);
        issue_start(1);
        wait_idle(1, GC1 + 20);
        check("b2b_gap", last_vc[1] - prev_vc[1], GC1 + 2);

        // Randomized rates and stray starts.
        for (int r = 0; r < 6; r++) begin
            hp_lo = int'($urandom_range(8, 1));
            hp_hi = hp_lo + int'($urandom_range(8, 0));
            repeat ($urandom_range(25, 0)) tick();
            issue_start(1);
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(900, 1)) tick();
                issue_start(1);
            end
            wait_idle(1, GC1 + 20);
        end

        // Reset in the middle of a 1 s measurement at 1 kHz, then a clean one.
        hp_lo = 20;
        hp_hi = 20;
        repeat (60) tick();
        issue_start(0);
        repeat (5000) tick();
        do_reset(3);
        repeat (5) tick();
        issue_start(0);
        wait_idle(0, GC0 + 20);
        check("khz_cnt_in_range", int'(f0 >= 16'd999 && f0 <= 16'd1001), 1);
        check("khz_ovf", int'(ovf_v[0]), 0);
        gen_on = 0;
        repeat (5) tick();

        for (int d = 0; d < NDUT; d++)
            check($sformatf("valid_count[%0d]", d), n_seen[d], n_exp[d]);
        check("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
